// File: rtl/macroblock_receiver_pkg.sv
// Shared image-processing definitions: macroblock types and default block geometry.
package macroblock_receiver_pkg;

   localparam int MB_BLOCK_PIXELS = 64;   // 8x8 macroblock
   localparam int MB_ADDR_W       = 6;    // log2(MB_BLOCK_PIXELS)
   localparam int MB_PIXEL_W      = 24;   // RGB24, {R, G, B}

   // Block content type; the first enumerator is the reset value.
   typedef enum logic [1:0] {
      MB_TYPE_LUMA     = 2'd0,
      MB_TYPE_CHROMA_B = 2'd1,
      MB_TYPE_CHROMA_R = 2'd2,
      MB_TYPE_RGB      = 2'd3
   } teMacroBlockType;

endpackage

// File: rtl/macroblock_receiver_if.sv
// Pixel-stream input plus random-access block read port of the macroblock receiver.
interface macroblock_receiver_if
   import macroblock_receiver_pkg::*;
#(
   parameter int ADDR_W = MB_ADDR_W
) ();

   // Transfer source side
   logic                    ul1EnTransfer;
   teMacroBlockType         eMacroBlockType;
   logic [MB_PIXEL_W-1:0]   ul24Rgb24Data;

   // Consumer side
   logic                    ul1BlockValid;
   teMacroBlockType         eBlockType;
   logic [ADDR_W-1:0]       ulRdAddr;
   logic [MB_PIXEL_W-1:0]   ul24RdData;
   logic                    ul1BlockDone;

   // Status
   logic                    ul1TypeError;
   logic                    ul1Overflow;
   logic                    ul1ClearErr;

   // Environment driving the receiver (transfer source + consumer)
   modport master (
      output ul1EnTransfer, eMacroBlockType, ul24Rgb24Data,
      output ulRdAddr, ul1BlockDone, ul1ClearErr,
      input  ul1BlockValid, eBlockType, ul24RdData, ul1TypeError, ul1Overflow
   );

   // The receiver itself
   modport slave (
      input  ul1EnTransfer, eMacroBlockType, ul24Rgb24Data,
      input  ulRdAddr, ul1BlockDone, ul1ClearErr,
      output ul1BlockValid, eBlockType, ul24RdData, ul1TypeError, ul1Overflow
   );

endinterface

// File: rtl/mb_pingpong_ram.sv
// Two-bank simple-dual-port pixel RAM: one write port, one registered read port.
// Address is {bank, pixel index}.
module mb_pingpong_ram #(
   parameter int RAM_ADDR_W = 7,
   parameter int DATA_W     = 24
) (
   input  logic                  ul1Clock,
   input  logic                  ul1Reset,
   input  logic                  i_wrEn,
   input  logic [RAM_ADDR_W-1:0] i_wrAddr,
   input  logic [DATA_W-1:0]     i_wrData,
   input  logic [RAM_ADDR_W-1:0] i_rdAddr,
   output logic [DATA_W-1:0]     o_rdData
);

   logic [DATA_W-1:0] r_mem [2**RAM_ADDR_W];
   logic [DATA_W-1:0] r_rdData;

   // Pixel storage write.
   // NOTE: the storage array has no reset; clearing it would stop it mapping onto RAM
   // macros, and block contents are never read before being written.
   always_ff @(posedge ul1Clock) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
   end

   // Registered read port; the output register is reset so the read data reads 0 in reset.
   always_ff @(posedge ul1Clock or posedge ul1Reset) begin
      if (ul1Reset) begin
         r_rdData <= '0;
      end else begin
         r_rdData <= r_mem[i_rdAddr];
      end
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/macroblock_receiver.sv
// Macroblock receiver: captures one raster-ordered block at a time into a ping-pong
// buffer and presents completed blocks, with their type, to a random-access consumer.
module macroblock_receiver
   import macroblock_receiver_pkg::*;
#(
   parameter int BLOCK_PIXELS = MB_BLOCK_PIXELS,
   parameter int ADDR_W       = MB_ADDR_W
) (
   input  logic                  ul1Clock,
   input  logic                  ul1Reset,
   macroblock_receiver_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLOCK_PIXELS - 1);

   // Write side
   logic              r_wBank;
   logic [ADDR_W-1:0] r_wCount;
   // Bank ownership and latched block types
   logic [1:0]        r_full;
   logic [1:0]        w_fullNext;
   teMacroBlockType   r_typeReg [2];
   // Read side
   logic              r_rBank;
   // Sticky status
   logic              r_typeErr;
   logic              r_overflow;

   logic              w_wrEn;
   logic              w_drop;
   logic              w_first;
   logic              w_complete;
   logic              w_release;
   logic              w_typeMis;
   logic [MB_PIXEL_W-1:0] w_rdData;

   // A pixel is stored only if the bank being filled is not held by the consumer;
   // the link has no backpressure, so otherwise the pixel is lost.
   assign w_wrEn     = bus.ul1EnTransfer & ~r_full[r_wBank];
   assign w_drop     = bus.ul1EnTransfer &  r_full[r_wBank];
   assign w_first    = (r_wCount == '0);
   assign w_complete = w_wrEn & (r_wCount == LAST_IDX);
   assign w_release  = bus.ul1BlockDone & r_full[r_rBank];
   assign w_typeMis  = w_wrEn & ~w_first & (bus.eMacroBlockType != r_typeReg[r_wBank]);

   // Next bank-full state: completion of one bank and release of the other may coincide.
   // NOTE: combinational blocks use blocking assignments and assign every output a
   // default first, so later conditions override cleanly and no latch is inferred.
   always_comb begin
      w_fullNext = r_full;
      if (w_release) begin
         w_fullNext[r_rBank] = 1'b0;
      end
      if (w_complete) begin
         w_fullNext[r_wBank] = 1'b1;
      end
   end

   // Write pointer: index within the block and the bank being filled.
   // NOTE: clocked blocks use non-blocking assignments so every register samples
   // the pre-edge values, independent of block ordering.
   always_ff @(posedge ul1Clock or posedge ul1Reset) begin
      if (ul1Reset) begin
         r_wCount <= '0;
         r_wBank  <= 1'b0;
      end else if (w_wrEn) begin
         if (w_complete) begin
            r_wCount <= '0;
            r_wBank  <= ~r_wBank;
         end else begin
            r_wCount <= r_wCount + 1'b1;
         end
      end
   end

   // Bank-full flags and read bank selection.
   always_ff @(posedge ul1Clock or posedge ul1Reset) begin
      if (ul1Reset) begin
         r_full  <= 2'b00;
         r_rBank <= 1'b0;
      end else begin
         r_full <= w_fullNext;
         if (w_release) begin
            r_rBank <= ~r_rBank;
         end
      end
   end

   // Block type is latched on the first pixel of each block and held for the block.
   always_ff @(posedge ul1Clock or posedge ul1Reset) begin
      if (ul1Reset) begin
         r_typeReg[0] <= MB_TYPE_LUMA;
         r_typeReg[1] <= MB_TYPE_LUMA;
      end else if (w_wrEn && w_first) begin
         r_typeReg[r_wBank] <= bus.eMacroBlockType;
      end
   end

   // Sticky error flags; a new error event takes priority over a clear request.
   always_ff @(posedge ul1Clock or posedge ul1Reset) begin
      if (ul1Reset) begin
         r_typeErr  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_typeMis) begin
            r_typeErr <= 1'b1;
         end else if (bus.ul1ClearErr) begin
            r_typeErr <= 1'b0;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (bus.ul1ClearErr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   mb_pingpong_ram #(
      .RAM_ADDR_W (ADDR_W + 1),
      .DATA_W     (MB_PIXEL_W)
   ) u_ram (
      .ul1Clock (ul1Clock),
      .ul1Reset (ul1Reset),
      .i_wrEn   (w_wrEn),
      .i_wrAddr ({r_wBank, r_wCount}),
      .i_wrData (bus.ul24Rgb24Data),
      .i_rdAddr ({r_rBank, bus.ulRdAddr}),
      .o_rdData (w_rdData)
   );

   assign bus.ul1BlockValid = r_full[r_rBank];
   assign bus.eBlockType    = r_typeReg[r_rBank];
   assign bus.ul24RdData    = w_rdData;
   assign bus.ul1TypeError  = r_typeErr;
   assign bus.ul1Overflow   = r_overflow;

endmodule
